// File: rtl/tt_sweep_checker_if.sv
// Bundle between the truth-table sweep checker and its environment:
// stimulus to the circuit under test, its output, the command and the results.
interface tt_sweep_checker_if;
  logic        start;
  logic        in1;
  logic        in2;
  logic        in3;
  logic        in4;
  logic        dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
  logic [15:0] mismatch;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;

  modport master (
    output start, dut_out,
    input  in1, in2, in3, in4, busy, done, pass,
    input  captured, mismatch, fail_count, first_fail
  );

  modport slave (
    input  start, dut_out,
    output in1, in2, in3, in4, busy, done, pass,
    output captured, mismatch, fail_count, first_fail
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 rows of a 4-input circuit, captures its truth table and
// compares it against EXPECTED (bit 15-r holds the output for row r).
module tt_sweep_checker #(
  parameter logic [15:0] EXPECTED = 16'hDA80,
  parameter int unsigned SETTLE   = 4
) (
  input logic              clk,
  input logic              rst,
  tt_sweep_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  stim_q, stim_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] captured_q, captured_d;
  logic [15:0] mismatch_q, mismatch_d;
  logic [4:0]  fail_count_q, fail_count_d;
  logic [3:0]  first_fail_q, first_fail_d;

  // Capture including the row being sampled now, so the results of the last
  // row can be registered on the same edge that enters DONE.
  logic [15:0] cap_fin;
  logic [15:0] mm_fin;
  logic [4:0]  fc_fin;
  logic [3:0]  ff_fin;
  logic        ff_found;

  always_comb begin
    cap_fin                  = captured_q;
    cap_fin[4'd15 - row_q]   = bus.dut_out;
    mm_fin                   = cap_fin ^ EXPECTED;
    fc_fin                   = '0;
    ff_fin                   = '0;
    ff_found                 = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      fc_fin = fc_fin + 5'(mm_fin[i]);
    end
    for (int unsigned r = 0; r < 16; r++) begin
      if (!ff_found && mm_fin[15 - r]) begin
        ff_fin   = 4'(r);
        ff_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    stim_d       = stim_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    captured_d   = captured_q;
    mismatch_d   = mismatch_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          captured_d   = '0;
          mismatch_d   = '0;
          fail_count_d = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
          row_d        = '0;
          stim_d       = '0;
          cnt_d        = RELOAD;
          busy_d       = 1'b1;
          state_d      = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        captured_d = cap_fin;
        if (row_q == 4'd15) begin
          mismatch_d   = mm_fin;
          fail_count_d = fc_fin;
          first_fail_d = ff_fin;
          pass_d       = (mm_fin == '0);
          stim_d       = '0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = DONE;
        end else begin
          row_d   = row_q + 4'd1;
          stim_d  = row_q + 4'd1;
          cnt_d   = RELOAD;
          state_d = APPLY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      stim_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      captured_q   <= '0;
      mismatch_q   <= '0;
      fail_count_q <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      captured_q   <= captured_d;
      mismatch_q   <= mismatch_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign bus.in1        = stim_q[3];
  assign bus.in2        = stim_q[2];
  assign bus.in3        = stim_q[1];
  assign bus.in4        = stim_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.captured   = captured_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.fail_count = fail_count_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: golden, stuck-at and inverted circuit
// models, stimulus ordering, ignored start, and reset handling.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   mode   = 0;
  logic golden;
  logic model_out;
  logic [3:0] stim;

  tt_sweep_checker_if bus();

  tt_sweep_checker #(.EXPECTED(16'hDA80), .SETTLE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign stim   = {bus.in1, bus.in2, bus.in3, bus.in4};
  assign golden = (~bus.in2 & ~bus.in3 & ~bus.in4) | (~bus.in1 & (bus.in2 ^ bus.in4));

  always_comb begin
    model_out = golden;
    case (mode)
      1:       model_out = 1'b0;
      2:       model_out = 1'b1;
      3:       model_out = ~golden;
      default: model_out = golden;
    endcase
  end
  assign bus.dut_out = model_out;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Pulses start, then samples each cycle after the accepting edge until done.
  // lat = cycles from accepting edge to done; bad = stimulus/busy violations.
  task automatic run_sweep(input int m, input int rep, output int lat, output int bad);
    mode = m;
    lat  = -1;
    bad  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (n > 0) @(negedge clk);
      bus.start = (n == rep);
      if (bus.done) begin
        lat = n;
        if (stim !== 4'd0 || bus.busy !== 1'b0) bad++;
        break;
      end
      if (n < 80 && (stim !== 4'(n / 5) || bus.busy !== 1'b1)) bad++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({stim, bus.busy, bus.done, bus.pass} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got stim=%h busy=%b done=%b pass=%b expected all 0",
               stim, bus.busy, bus.done, bus.pass);
    end
    checks++;
    if ({bus.captured, bus.mismatch, bus.fail_count, bus.first_fail} !== 41'd0) begin
      errors++;
      $display("FAIL reset_results: got cap=%h mm=%h fc=%0d ff=%0d expected all 0",
               bus.captured, bus.mismatch, bus.fail_count, bus.first_fail);
    end
    rst = 1'b0;
  endtask

  task automatic test_golden();
    int lat, bad;
    run_sweep(0, -1, lat, bad);
    checks++;
    if (lat !== 80) begin errors++; $display("FAIL golden_latency: got %0d expected 80", lat); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL golden_stimulus: got %0d bad samples expected 0", bad); end
    checks++;
    if ({bus.captured, bus.mismatch, bus.fail_count, bus.first_fail, bus.pass} !== {16'hDA80, 16'h0000, 5'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL golden_results: got cap=%h mm=%h fc=%0d ff=%0d pass=%b expected DA80 0000 0 0 1",
               bus.captured, bus.mismatch, bus.fail_count, bus.first_fail, bus.pass);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got done=%b expected 0", bus.done); end
    repeat (6) @(negedge clk);
    checks++;
    if ({bus.captured, bus.pass, bus.busy} !== {16'hDA80, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL results_hold: got cap=%h pass=%b busy=%b expected DA80 1 0",
               bus.captured, bus.pass, bus.busy);
    end
  endtask

  task automatic test_patterns();
    int lat, bad;
    int          modes [3] = '{1, 2, 3};
    logic [15:0] ecap  [3] = '{16'h0000, 16'hFFFF, 16'h257F};
    logic [15:0] emm   [3] = '{16'hDA80, 16'h257F, 16'hFFFF};
    logic [4:0]  efc   [3] = '{5'd6, 5'd10, 5'd16};
    logic [3:0]  eff   [3] = '{4'd0, 4'd2, 4'd0};
    for (int t = 0; t < 3; t++) begin
      run_sweep(modes[t], -1, lat, bad);
      checks++;
      if (lat !== 80 || bad !== 0) begin
        errors++;
        $display("FAIL pattern%0d_timing: got lat=%0d bad=%0d expected 80 0", modes[t], lat, bad);
      end
      checks++;
      if ({bus.captured, bus.mismatch, bus.fail_count, bus.first_fail, bus.pass} !== {ecap[t], emm[t], efc[t], eff[t], 1'b0}) begin
        errors++;
        $display("FAIL pattern%0d_results: got cap=%h mm=%h fc=%0d ff=%0d pass=%b expected %h %h %0d %0d 0",
                 modes[t], bus.captured, bus.mismatch, bus.fail_count, bus.first_fail, bus.pass,
                 ecap[t], emm[t], efc[t], eff[t]);
      end
    end
  endtask

  task automatic test_clear_on_start();
    int n;
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.captured, bus.mismatch, bus.fail_count, bus.first_fail, bus.pass, bus.busy} !== {41'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clear_on_start: got cap=%h mm=%h fc=%0d ff=%0d pass=%b busy=%b expected 0 0 0 0 0 1",
               bus.captured, bus.mismatch, bus.fail_count, bus.first_fail, bus.pass, bus.busy);
    end
    n = 0;
    while (!bus.done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n !== 80 || bus.pass !== 1'b1) begin
      errors++;
      $display("FAIL clear_sweep_finish: got lat=%0d pass=%b expected 80 1", n, bus.pass);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad, extra;
    run_sweep(0, 40, lat, bad);
    checks++;
    if (lat !== 80 || bad !== 0) begin
      errors++;
      $display("FAIL restart_ignored: got lat=%0d bad=%0d expected 80 0", lat, bad);
    end
    extra = 0;
    repeat (20) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL restart_no_second: got %0d busy/done cycles expected 0", extra); end
  endtask

  task automatic test_rst_mid();
    int n, seen;
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (stim !== 4'd7 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== 35) begin errors++; $display("FAIL row7_reach: got %0d cycles expected 35", n); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({stim, bus.busy, bus.done, bus.pass, bus.captured, bus.mismatch, bus.fail_count, bus.first_fail} !== 48'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got stim=%h busy=%b done=%b cap=%h expected all 0",
               stim, bus.busy, bus.done, bus.captured);
    end
    seen = 0;
    repeat (100) begin @(negedge clk); if (bus.done || bus.busy) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d busy/done cycles expected 0", seen); end
    test_golden();
  endtask

  task automatic test_rst_start();
    int seen;
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    seen = 0;
    repeat (10) begin if (bus.busy || bus.done || stim != 4'd0) seen++; @(negedge clk); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_start_idle: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_golden();
    test_patterns();
    test_clear_on_start();
    test_back_to_back();
    test_rst_mid();
    test_rst_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
